clos_cm_sync_buf: RTL and testbench

CLOS_CM_SYNC_BUF -- requirements
Module: clos_cm_sync_buf

---
 rtl/clos_cm_sync_buf.sv | 182 ++++++++++++++++++
 tb/tb_clos_cm_sync_buf.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clos_cm_sync_buf.sv
// Output-buffered KN x KN crossbar: every output owns a FIFO and locks to one input for a whole packet.
// Define CLOS_CM_RR_EN for round-robin head arbitration; the default build uses fixed lowest-index priority.

module clos_cm_sync_port #(
    parameter int KN    = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KN-1:0]    i_req,
    input  logic [KN*DW-1:0] i_data,
    input  logic [KN-1:0]    i_eof,
    output logic [KN-1:0]    o_grant,
    output logic [DW-1:0]    o_data,
    output logic             o_eof,
    output logic             o_valid,
    input  logic             i_ready
);
    localparam int OW = (KN > 1) ? $clog2(KN) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_LOCKED = 1'b1;

    logic          r_state;
    logic [OW-1:0] r_owner;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [DW:0]   r_mem [DEPTH];

    logic          w_full;
    logic          w_any;
    logic          w_push;
    logic          w_pop;
    logic          w_eof;
    logic [DW-1:0] w_data;
    logic [OW-1:0] w_win;
    logic [OW-1:0] w_src;

    // Eligibility looks at the registered count only, so a same-cycle pop never frees a slot.
    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_any  = |i_req;

`ifdef CLOS_CM_RR_EN
    logic [OW-1:0] r_rrp;

    always_comb begin
        logic [OW:0] idx;
        idx   = '0;
        w_win = '0;
        for (int k = KN-1; k >= 0; k--) begin
            idx = {1'b0, r_rrp} + (OW+1)'(k);
            if (idx >= (OW+1)'(KN)) idx = idx - (OW+1)'(KN);
            if (i_req[idx[OW-1:0]]) w_win = idx[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rrp <= '0;
        else if (w_push && r_state == S_IDLE)
            r_rrp <= (w_win == OW'(KN-1)) ? '0 : w_win + 1'b1;
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = KN-1; k >= 0; k--)
            if (i_req[k]) w_win = OW'(k);
    end
`endif

    always_comb begin
        w_push  = 1'b0;
        w_src   = r_owner;
        o_grant = '0;
        if (!rst) begin
            if (r_state == S_IDLE) begin
                w_src  = w_win;
                w_push = w_any && !w_full;
            end else begin
                w_push = i_req[r_owner] && !w_full;
            end
        end
        if (w_push) o_grant[w_src] = 1'b1;
    end

    assign w_eof   = i_eof[w_src];
    assign w_data  = i_data[int'(w_src)*DW +: DW];
    assign o_valid = !rst && (r_count != '0);
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push) begin
                if (r_state == S_IDLE && !w_eof) begin
                    r_state <= S_LOCKED;
                    r_owner <= w_src;
                end else if (r_state == S_LOCKED && w_eof) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_eof, w_data};
    end

    assign {o_eof, o_data} = r_mem[r_rptr];
endmodule

module clos_cm_sync_buf #(
    parameter int KN    = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KN*DW-1:0] in_data,
    input  logic [KN-1:0]    in_eof,
    input  logic [KN-1:0]    in_valid,
    input  logic [KN*KN-1:0] in_dst,
    output logic [KN-1:0]    in_ready,
    output logic [KN*DW-1:0] out_data,
    output logic [KN-1:0]    out_eof,
    output logic [KN-1:0]    out_valid,
    input  logic [KN-1:0]    out_ready
);
    logic [KN-1:0][KN-1:0] w_low;
    logic [KN-1:0][KN-1:0] w_req;
    logic [KN-1:0][KN-1:0] w_grant;

    // Only the lowest set destination bit counts, so each input targets at most one output.
    always_comb begin
        w_low = '0;
        w_req = '0;
        for (int i = 0; i < KN; i++)
            w_low[i] = in_dst[i*KN +: KN] & (~in_dst[i*KN +: KN] + KN'(1));
        for (int o = 0; o < KN; o++)
            for (int i = 0; i < KN; i++)
                w_req[o][i] = in_valid[i] & w_low[i][o];
    end

    always_comb begin
        in_ready = '0;
        for (int o = 0; o < KN; o++)
            in_ready = in_ready | w_grant[o];
    end

    for (genvar o = 0; o < KN; o++) begin : g_port
        clos_cm_sync_port #(
            .KN    (KN),
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .i_req   (w_req[o]),
            .i_data  (in_data),
            .i_eof   (in_eof),
            .o_grant (w_grant[o]),
            .o_data  (out_data[o*DW +: DW]),
            .o_eof   (out_eof[o]),
            .o_valid (out_valid[o]),
            .i_ready (out_ready[o])
        );
    end
endmodule

// File: tb/tb_clos_cm_sync_buf.sv
// Directed and randomized checks of clos_cm_sync_buf against a queue-per-output packet model.
module tb_clos_cm_sync_buf;
    localparam int KN    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [KN*DW-1:0] in_data = '0;
    logic [KN-1:0]    in_eof = '0;
    logic [KN-1:0]    in_valid = '0;
    logic [KN*KN-1:0] in_dst = '0;
    logic [KN-1:0]    in_ready;
    logic [KN*DW-1:0] out_data;
    logic [KN-1:0]    out_eof;
    logic [KN-1:0]    out_valid;
    logic [KN-1:0]    out_ready = '0;

    always #5 clk = ~clk;

    clos_cm_sync_buf #(.KN(KN), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_eof    (in_eof),
        .in_valid  (in_valid),
        .in_dst    (in_dst),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_eof   (out_eof),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a flit queue per output, the input currently holding it (-1 = free), rr start.
    logic [DW:0]      mq [KN][$];
    int               lock_own [KN];
    int               rrp [KN];
    int               m_src [KN];
    logic [KN-1:0]    m_push, exp_ready, exp_oval, exp_eof;
    logic [KN*DW-1:0] exp_data, dmask;

    function automatic int low_dst(int i);
        for (int o = 0; o < KN; o++)
            if (in_dst[i*KN + o]) return o;
        return -1;
    endfunction

    task automatic model_eval();
        exp_ready = '0; exp_oval = '0; exp_eof = '0;
        exp_data = '0; dmask = '0; m_push = '0;
        for (int o = 0; o < KN; o++) begin
            bit reqs [KN];
            int w;
            m_src[o] = -1;
            w = -1;
            for (int i = 0; i < KN; i++) reqs[i] = in_valid[i] && (low_dst(i) == o);
            if (lock_own[o] >= 0) begin
                if (reqs[lock_own[o]]) w = lock_own[o];
            end else begin
`ifdef CLOS_CM_RR_EN
                for (int k = KN-1; k >= 0; k--) if (reqs[(rrp[o]+k) % KN]) w = (rrp[o]+k) % KN;
`else
                for (int k = KN-1; k >= 0; k--) if (reqs[k]) w = k;
`endif
            end
            if (!rst && mq[o].size() < DEPTH && w >= 0) begin
                m_push[o] = 1'b1;
                m_src[o] = w;
                exp_ready[w] = 1'b1;
            end
            if (!rst && mq[o].size() > 0) begin
                exp_oval[o] = 1'b1;
                exp_eof[o] = mq[o][0][DW];
                exp_data[o*DW +: DW] = mq[o][0][DW-1:0];
                dmask[o*DW +: DW] = '1;
            end
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < KN; o++) begin
            if (rst) begin
                mq[o].delete();
                lock_own[o] = -1;
                rrp[o] = 0;
            end else begin
                if (exp_oval[o] && out_ready[o]) void'(mq[o].pop_front());
                if (m_push[o]) begin
                    int s;
                    s = m_src[o];
                    mq[o].push_back({in_eof[s], in_data[s*DW +: DW]});
                    if (lock_own[o] < 0) begin
                        rrp[o] = (s + 1) % KN;
                        if (!in_eof[s]) lock_own[o] = s;
                    end else if (in_eof[s]) begin
                        lock_own[o] = -1;
                    end
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_in(int i, bit v, int o, logic [DW-1:0] d, bit e);
        in_valid[i] = v;
        in_dst[i*KN +: KN] = (o < 0) ? KN'(0) : (KN'(1) << o);
        in_data[i*DW +: DW] = d;
        in_eof[i] = e;
    endtask

    task automatic clear_in();
        in_valid = '0; in_dst = '0; in_data = '0; in_eof = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        out_ready = '0;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            rst = (c < 3);
            for (int i = 0; i < KN; i++) set_in(i, 1'b1, int'($urandom_range(0, KN-1)), DW'($urandom), 1'b0);
            if (c == 3) clear_in();
            out_ready = '1;
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL reset ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL reset valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            advance();
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        out_ready = '1;
        for (int c = 0; c < 12; c++) begin
            set_in(0, 1'b1, 2, DW'(8'h00 + c), 1'b1);
            set_in(1, 1'b1, 2, DW'(8'h80 + c), 1'b1);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL arb ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL arb valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL arb data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            advance();
        end
        clear_in();
    endtask

    task automatic test_packet_lock();
        int a;
        bit b_done;
        a = 0; b_done = 0;
        do_reset();
        out_ready = '1;
        for (int c = 0; c < 9; c++) begin
            set_in(3, a < 3, 0, DW'(8'hA0 + a), a == 2);
            set_in(4, c >= 2 && !b_done, 0, 8'hB0, 1'b1);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL lock ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL lock valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL lock data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            if (exp_ready[3]) a++;
            if (exp_ready[4]) b_done = 1;
            advance();
        end
        clear_in();
    endtask

    task automatic test_full();
        int n;
        n = 0;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            out_ready = (c < 7) ? KN'(0) : KN'(5'b00010);
            set_in(0, 1'b1, 1, DW'(8'h30 + n), 1'b1);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL full ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL full valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL full data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            if (exp_ready[0]) n++;
            advance();
        end
        clear_in();
    endtask

    task automatic test_parallel();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_in();
            if (c == 0) for (int i = 0; i < KN; i++) set_in(i, 1'b1, KN-1-i, DW'($urandom), 1'b1);
            out_ready = (c == 2) ? KN'('1) : KN'(0);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL par ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL par valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL par data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            advance();
        end
        clear_in();
    endtask

    task automatic test_reset_midpacket();
        int d;
        d = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            clear_in();
            rst = (c == 2);
            out_ready = (c < 3) ? KN'(0) : KN'('1);
            if (c <= 2) set_in(2, 1'b1, 0, DW'(8'hC0 + c), 1'b0);
            if (c >= 3 && d < 3) set_in(4, 1'b1, 0, DW'(8'hD0 + d), d == 2);
            if (c >= 4) set_in(1, 1'b1, 0, 8'hE0, 1'b1);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL midrst ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL midrst valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL midrst data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            if (exp_ready[4]) d++;
            advance();
        end
        rst = 1'b0;
        clear_in();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < KN; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_dst[i*KN +: KN] = ($urandom_range(0, 3) == 0) ? KN'($urandom_range(0, 31))
                                                                 : (KN'(1) << $urandom_range(0, KN-1));
                in_eof[i] = ($urandom_range(0, 2) == 0);
                in_data[i*DW +: DW] = DW'($urandom);
            end
            out_ready = (c < 400) ? KN'($urandom) : KN'($urandom | $urandom);
            #1; model_eval();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rand ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_oval) begin n_err++; $display("FAIL rand valid c%0d: got %b want %b", c, out_valid, exp_oval); end
            n_vec++; if ((out_data & dmask) !== exp_data || (out_eof & exp_oval) !== exp_eof) begin
                n_err++; $display("FAIL rand data c%0d: got %h/%b want %h/%b", c, out_data & dmask, out_eof & exp_oval, exp_data, exp_eof); end
            advance();
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        for (int o = 0; o < KN; o++) begin
            lock_own[o] = -1;
            rrp[o] = 0;
        end
        @(negedge clk);
        test_reset();
        test_arbitration();
        test_packet_lock();
        test_full();
        test_parallel();
        test_reset_midpacket();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
